// File: rtl/gamepad_pmod_pkg.sv
// Shared definitions for the Gamepad Pmod link (driver and receiver).
//   GAMEPAD_FRAME_BITS : bits per serial frame
//   GAMEPAD_ABSENT     : word seen by the receiver when no controller is connected
//   BTN_*              : bit positions of each button inside the 12-bit word
//   gp_state_e         : serializer state encoding
package gamepad_pmod_pkg;

    localparam int GAMEPAD_FRAME_BITS = 12;
    localparam logic [GAMEPAD_FRAME_BITS-1:0] GAMEPAD_ABSENT = 12'hFFF;

    localparam int BTN_B      = 11;
    localparam int BTN_Y      = 10;
    localparam int BTN_SELECT = 9;
    localparam int BTN_START  = 8;
    localparam int BTN_UP     = 7;
    localparam int BTN_DOWN   = 6;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_RIGHT  = 4;
    localparam int BTN_A      = 3;
    localparam int BTN_X      = 2;
    localparam int BTN_L      = 1;
    localparam int BTN_R      = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } gp_state_e;

endpackage

// File: rtl/gamepad_pmod_driver_if.sv
// Host handshake plus Pmod pin bundle for gamepad_pmod_driver.
//   buttons/present/start : request side, driven by the host (master)
//   ready/done            : handshake status, driven by the driver (slave)
//   pmod_latch/clk/data   : serial pins, driven by the driver (slave)
interface gamepad_pmod_driver_if;
    import gamepad_pmod_pkg::*;

    logic [GAMEPAD_FRAME_BITS-1:0] buttons;
    logic                          present;
    logic                          start;
    logic                          ready;
    logic                          done;
    logic                          pmod_latch;
    logic                          pmod_clk;
    logic                          pmod_data;

    modport master (
        output buttons, present, start,
        input  ready, done, pmod_latch, pmod_clk, pmod_data
    );

    modport slave (
        input  buttons, present, start,
        output ready, done, pmod_latch, pmod_clk, pmod_data
    );

endinterface

// File: rtl/gamepad_pmod_driver.sv
// Serializes a 12-bit SNES button word onto the Gamepad Pmod latch/clk/data
// pins, one frame per accepted start.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : gamepad_pmod_driver_if.slave (buttons, present, start in;
//           ready, done, pmod_latch, pmod_clk, pmod_data out)
//   CLK_DIV : pmod_clk half-period in clk cycles, legal 1..255
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready=1, pins low, waiting for start
// ST_SHIFT | sending bits 11..0, one per 2*CLK_DIV cycles
// ST_LATCH | latch strobe high for CLK_DIV cycles, then done pulse
module gamepad_pmod_driver
    import gamepad_pmod_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gamepad_pmod_driver_if.slave  bus
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    gp_state_e                     state;
    logic [7:0]                    div_cnt;
    logic [3:0]                    bit_cnt;
    logic [GAMEPAD_FRAME_BITS-1:0] shift_reg;
    logic [GAMEPAD_FRAME_BITS-1:0] frame_word;
    logic                          div_tc;

    logic ready_q;
    logic done_q;
    logic latch_q;
    logic pclk_q;
    logic data_q;

    assign frame_word = bus.present ? bus.buttons : GAMEPAD_ABSENT;
    assign div_tc     = (div_cnt == DIV_LAST);

    assign bus.ready      = ready_q;
    assign bus.done       = done_q;
    assign bus.pmod_latch = latch_q;
    assign bus.pmod_clk   = pclk_q;
    assign bus.pmod_data  = data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            latch_q   <= 1'b0;
            pclk_q    <= 1'b0;
            data_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        shift_reg <= frame_word;
                        data_q    <= frame_word[GAMEPAD_FRAME_BITS-1];
                        bit_cnt   <= 4'(GAMEPAD_FRAME_BITS - 1);
                        div_cnt   <= '0;
                        ready_q   <= 1'b0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        if (!pclk_q) begin
                            pclk_q <= 1'b1;
                        end else begin
                            // Bit period ends on the falling edge, so data only
                            // ever moves while pmod_clk is low.
                            pclk_q    <= 1'b0;
                            shift_reg <= {shift_reg[GAMEPAD_FRAME_BITS-2:0], 1'b0};
                            if (bit_cnt == 4'd0) begin
                                data_q  <= 1'b0;
                                latch_q <= 1'b1;
                                state   <= ST_LATCH;
                            end else begin
                                bit_cnt <= bit_cnt - 4'd1;
                                data_q  <= shift_reg[GAMEPAD_FRAME_BITS-2];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_LATCH: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        latch_q <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gamepad_pmod_driver.sv
// Directed bench for gamepad_pmod_driver: one instance at CLK_DIV=2 and one
// at CLK_DIV=1. A per-cycle monitor reconstructs each frame from the pins
// (bits captured on pmod_clk rising, latch width, done timing), and the main
// sequence compares those observations with hand-computed values.
module tb_gamepad_pmod_driver;
    import gamepad_pmod_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gamepad_pmod_driver_if bus0 ();
    gamepad_pmod_driver_if bus1 ();

    gamepad_pmod_driver #(.CLK_DIV(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    gamepad_pmod_driver #(.CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic        prev_rdy   [2] = '{1'b0, 1'b0};
    logic        prev_pclk  [2] = '{1'b0, 1'b0};
    logic        prev_data  [2] = '{1'b0, 1'b0};
    logic        prev_latch [2] = '{1'b0, 1'b0};
    logic [11:0] cap        [2] = '{12'h0, 12'h0};
    int          nbits      [2];
    int          bits_at    [2];
    int          lat_run    [2];
    int          latch_w    [2];
    int          n_latch    [2];
    int          n_done     [2];
    int          setup_err  [2];
    int          first_rise [2];
    int          frame_start[2];
    int          done_cyc   [2];
    int          nwords     [2];
    int          nframes    [2];
    logic [11:0] words      [2][16];
    int          starts     [2][16];

    task automatic mon(input int i, input logic rdy, input logic dn,
                       input logic lt, input logic pc, input logic pd);
        if (prev_rdy[i] === 1'b1 && rdy === 1'b0) begin
            frame_start[i] = cyc;
            starts[i][nframes[i] % 16] = cyc;
            nframes[i]++;
            cap[i]   = '0;
            nbits[i] = 0;
        end
        if (prev_pclk[i] === 1'b0 && pc === 1'b1) begin
            if (nbits[i] == 0) first_rise[i] = cyc;
            cap[i] = {cap[i][10:0], pd};
            nbits[i]++;
            if (pd !== prev_data[i]) setup_err[i]++;
        end
        if (lt === 1'b1) lat_run[i]++;
        if (prev_latch[i] === 1'b0 && lt === 1'b1) begin
            n_latch[i]++;
            words[i][nwords[i] % 16] = cap[i];
            bits_at[i] = nbits[i];
            nwords[i]++;
        end
        if (prev_latch[i] === 1'b1 && lt === 1'b0) begin
            latch_w[i] = lat_run[i];
            lat_run[i] = 0;
        end
        if (dn === 1'b1) begin
            n_done[i]++;
            done_cyc[i] = cyc;
        end
        prev_rdy[i]   = rdy;
        prev_pclk[i]  = pc;
        prev_data[i]  = pd;
        prev_latch[i] = lt;
    endtask

    always @(negedge clk) begin
        mon(0, bus0.ready, bus0.done, bus0.pmod_latch, bus0.pmod_clk, bus0.pmod_data);
        mon(1, bus1.ready, bus1.done, bus1.pmod_latch, bus1.pmod_clk, bus1.pmod_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int i, input int base, input int budget, input string tag);
        int n = 0;
        while (n_done[i] <= base && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(tag, 32'(n_done[i] > base), 32'd1);
    endtask

    function automatic logic [11:0] word_at(input int i, input int k);
        return words[i][k % 16];
    endfunction

    int bd, bl, bw, bf;

    initial begin
        bus0.start = 1'b0; bus0.buttons = '0; bus0.present = 1'b1;
        bus1.start = 1'b0; bus1.buttons = '0; bus1.present = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst0_ready", bus0.ready, 1);
        check("rst0_done",  bus0.done, 0);
        check("rst0_latch", bus0.pmod_latch, 0);
        check("rst0_clk",   bus0.pmod_clk, 0);
        check("rst0_data",  bus0.pmod_data, 0);
        check("rst1_ready", bus1.ready, 1);
        check("rst1_done",  bus1.done, 0);
        check("rst1_latch", bus1.pmod_latch, 0);
        check("rst1_clk",   bus1.pmod_clk, 0);
        check("rst1_data",  bus1.pmod_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single frame, one button, CLK_DIV=2
        bd = n_done[0]; bl = n_latch[0]; bw = nwords[0];
        bus0.buttons = 12'h010; bus0.present = 1'b1; bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_done(0, bd, 200, "t1_done_seen");
        check("t1_word",       word_at(0, bw), 12'h010);
        check("t1_present",    32'(word_at(0, bw) != GAMEPAD_ABSENT), 1);
        check("t1_nbits",      bits_at[0], 12);
        check("t1_latch_w",    latch_w[0], 2);
        check("t1_latch_cnt",  n_latch[0] - bl, 1);
        check("t1_done_cycle", done_cyc[0] - frame_start[0], 50);
        check("t1_first_rise", first_rise[0] - frame_start[0], 2);
        check("t1_setup",      setup_err[0], 0);

        // controller absent
        bd = n_done[0]; bw = nwords[0];
        bus0.buttons = 12'h000; bus0.present = 1'b0; bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_done(0, bd, 200, "t2_done_seen");
        check("t2_word",   word_at(0, bw), 12'hFFF);
        check("t2_absent", 32'(word_at(0, bw) == GAMEPAD_ABSENT), 1);

        // start held for three frames, buttons changed mid-frame
        bd = n_done[0]; bw = nwords[0]; bf = nframes[0];
        bus0.present = 1'b1; bus0.buttons = 12'h111; bus0.start = 1'b1;
        repeat (20) @(negedge clk);
        bus0.buttons = 12'h222;
        repeat (51) @(negedge clk);
        bus0.buttons = 12'h333;
        repeat (51) @(negedge clk);
        bus0.buttons = 12'h444; bus0.start = 1'b0;
        wait_done(0, bd + 2, 100, "t3_done_seen");
        repeat (10) @(negedge clk);
        check("t3_word0",   word_at(0, bw),     12'h111);
        check("t3_word1",   word_at(0, bw + 1), 12'h222);
        check("t3_word2",   word_at(0, bw + 2), 12'h333);
        check("t3_gap01",   starts[0][(bf + 1) % 16] - starts[0][bf % 16], 51);
        check("t3_gap12",   starts[0][(bf + 2) % 16] - starts[0][(bf + 1) % 16], 51);
        check("t3_ndone",   n_done[0] - bd, 3);
        check("t3_nframes", nframes[0] - bf, 3);

        // start during SHIFT is ignored
        bd = n_done[0]; bl = n_latch[0]; bw = nwords[0]; bf = nframes[0];
        bus0.buttons = 12'h5A5; bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (10) @(negedge clk);
        bus0.buttons = 12'h0F0; bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_done(0, bd, 200, "t4_done_seen");
        repeat (80) @(negedge clk);
        check("t4_word",    word_at(0, bw), 12'h5A5);
        check("t4_ndone",   n_done[0] - bd, 1);
        check("t4_nlatch",  n_latch[0] - bl, 1);
        check("t4_nframes", nframes[0] - bf, 1);

        // reset during bit 5
        bd = n_done[0]; bl = n_latch[0];
        bus0.buttons = 12'hFFF; bus0.present = 1'b1; bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (25) @(negedge clk);
        check("t5_pre_data", bus0.pmod_data, 1);
        check("t5_pre_ready", bus0.ready, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_ready", bus0.ready, 1);
        check("t5_rst_done",  bus0.done, 0);
        check("t5_rst_latch", bus0.pmod_latch, 0);
        check("t5_rst_clk",   bus0.pmod_clk, 0);
        check("t5_rst_data",  bus0.pmod_data, 0);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("t5_no_done",  n_done[0] - bd, 0);
        check("t5_no_latch", n_latch[0] - bl, 0);
        bd = n_done[0]; bw = nwords[0];
        bus0.buttons = 12'h0C3; bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_done(0, bd, 200, "t5_after_done_seen");
        check("t5_after_word", word_at(0, bw), 12'h0C3);
        check("t5_after_done_cycle", done_cyc[0] - frame_start[0], 50);

        // CLK_DIV=1
        bd = n_done[1]; bw = nwords[1];
        bus1.buttons = 12'hA5A; bus1.present = 1'b1; bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        wait_done(1, bd, 100, "t6_done_seen");
        check("t6_word",       word_at(1, bw), 12'hA5A);
        check("t6_nbits",      bits_at[1], 12);
        check("t6_setup",      setup_err[1], 0);
        check("t6_latch_w",    latch_w[1], 1);
        check("t6_done_cycle", done_cyc[1] - frame_start[1], 25);
        check("t6_first_rise", first_rise[1] - frame_start[1], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
